axi_cmd_reg_map: RTL and testbench



---
 rtl/axi_cmd_reg_map.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_cmd_reg_map.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cmd_reg_map.sv
// Command-stream register map: chirp-write frames update the parameter bank,
// chirp-read frames return an AXI-Stream readback. Optional macro RESP_ID_WORD_EN.
//
// state   | meaning
// HDR     | waiting for the command word (beat 0) of a frame
// WR_ADDR | write frame, next beat is a register address
// WR_DATA | write frame, next beat is data for the latched address
// RD_ID   | readback id beat pending behind the header (RESP_ID_WORD_EN only)
// RD_ADDR | read frame, each beat is an address to return
// DRAIN   | unknown tdest, discarding beats until tlast
module axi_cmd_reg_map #(
  parameter int          NUM_REG       = 6,
  parameter logic [31:0] RESET_VAL     = 32'h0,
  parameter logic [31:0] BAD_ADDR_WORD = 32'hDEADBEEF
) (
  input  logic                   axi_tclk,
  input  logic                   axi_tresetn,
  input  logic [31:0]            s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  input  logic [3:0]             s_axis_tdest,
  input  logic [31:0]            s_axis_tuser,
  output logic                   s_axis_tready,
  output logic [31:0]            m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  output logic [31:0]            m_axis_tuser,
  input  logic                   m_axis_tready,
  output logic [32*NUM_REG-1:0]  reg_map_out,
  output logic                   reg_update,
  output logic [7:0]             err_count,
  output logic [7:0]             drop_count
);

  localparam logic [31:0] HDR_WORD  = 32'h52524343;
  localparam logic [7:0]  NUM_REG_B = 8'(NUM_REG);

  typedef enum logic [2:0] {
    HDR     = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
`ifdef RESP_ID_WORD_EN
    RD_ID   = 3'd3,
`endif
    RD_ADDR = 3'd4,
    DRAIN   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic        addr_ok_q, addr_ok_d;
  logic [31:0] tuser_q, tuser_d;
  logic [31:0] regs_q [NUM_REG];
  logic [31:0] regs_d [NUM_REG];
  logic [31:0] m_data_q, m_data_d;
  logic [31:0] m_user_q, m_user_d;
  logic        m_last_q, m_last_d;
  logic        m_valid_q, m_valid_d;
  logic        upd_q, upd_d;
  logic [7:0]  err_q, err_d;
  logic [7:0]  drop_q, drop_d;
  logic        rdy_en_q;
`ifdef RESP_ID_WORD_EN
  logic        hdr_last_q, hdr_last_d;
`endif

  logic        out_free, rdy, acc, s_ok, err_inc, drop_inc;
  logic [31:0] rd_word;

  assign out_free = !m_valid_q || m_axis_tready;
  assign s_ok     = (s_axis_tdata[31:8] == 24'd0) && (s_axis_tdata[7:0] < NUM_REG_B);

  always_comb begin
    rd_word = BAD_ADDR_WORD;
    for (int k = 0; k < NUM_REG; k++) begin
      if (s_ok && s_axis_tdata[7:0] == 8'(k)) rd_word = regs_q[k];
    end
  end

  always_comb begin
    rdy = 1'b0;
    case (state_q)
      HDR, RD_ADDR:            rdy = out_free;
      WR_ADDR, WR_DATA, DRAIN: rdy = 1'b1;
      default:                 rdy = 1'b0;
    endcase
  end

  // rdy_en_q keeps the input stalled while reset is asserted
  assign s_axis_tready = rdy_en_q && rdy;
  assign acc           = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    addr_ok_d = addr_ok_q;
    tuser_d   = tuser_q;
    regs_d    = regs_q;
    m_data_d  = m_data_q;
    m_user_d  = m_user_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q && !m_axis_tready;
    upd_d     = 1'b0;
    err_inc   = 1'b0;
    drop_inc  = 1'b0;
`ifdef RESP_ID_WORD_EN
    hdr_last_d = hdr_last_q;
`endif
    case (state_q)
      HDR: if (acc) begin
        tuser_d = s_axis_tuser;
        if (s_axis_tdest == 4'd0) begin
          state_d = s_axis_tlast ? HDR : WR_ADDR;
        end else if (s_axis_tdest == 4'd2) begin
          m_valid_d = 1'b1;
          m_data_d  = HDR_WORD;
          m_user_d  = s_axis_tuser;
`ifdef RESP_ID_WORD_EN
          m_last_d   = 1'b0;
          hdr_last_d = s_axis_tlast;
          state_d    = RD_ID;
`else
          m_last_d = s_axis_tlast;
          state_d  = s_axis_tlast ? HDR : RD_ADDR;
`endif
        end else begin
          drop_inc = 1'b1;
          state_d  = s_axis_tlast ? HDR : DRAIN;
        end
      end
      WR_ADDR: if (acc) begin
        if (s_axis_tlast) begin
          err_inc = 1'b1;
          state_d = HDR;
        end else begin
          addr_d    = s_axis_tdata[7:0];
          addr_ok_d = s_ok;
          state_d   = WR_DATA;
        end
      end
      WR_DATA: if (acc) begin
        if (addr_ok_q) begin
          for (int k = 0; k < NUM_REG; k++) begin
            if (addr_q == 8'(k)) regs_d[k] = s_axis_tdata;
          end
          upd_d = 1'b1;
        end else begin
          err_inc = 1'b1;
        end
        state_d = s_axis_tlast ? HDR : WR_ADDR;
      end
`ifdef RESP_ID_WORD_EN
      RD_ID: if (m_valid_q && m_axis_tready) begin
        m_valid_d = 1'b1;
        m_data_d  = tuser_q;
        m_user_d  = tuser_q;
        m_last_d  = hdr_last_q;
        state_d   = hdr_last_q ? HDR : RD_ADDR;
      end
`endif
      RD_ADDR: if (acc) begin
        m_valid_d = 1'b1;
        m_data_d  = rd_word;
        m_user_d  = tuser_q;
        m_last_d  = s_axis_tlast;
        err_inc   = !s_ok;
        if (s_axis_tlast) state_d = HDR;
      end
      DRAIN: if (acc && s_axis_tlast) state_d = HDR;
      default: state_d = HDR;
    endcase
    err_d  = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    drop_d = (drop_inc && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
    if (!axi_tresetn) begin
      state_q   <= HDR;
      addr_q    <= 8'd0;
      addr_ok_q <= 1'b0;
      tuser_q   <= 32'd0;
      for (int k = 0; k < NUM_REG; k++) regs_q[k] <= RESET_VAL;
      m_data_q  <= 32'd0;
      m_user_q  <= 32'd0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
      upd_q     <= 1'b0;
      err_q     <= 8'd0;
      drop_q    <= 8'd0;
      rdy_en_q  <= 1'b0;
`ifdef RESP_ID_WORD_EN
      hdr_last_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      addr_ok_q <= addr_ok_d;
      tuser_q   <= tuser_d;
      regs_q    <= regs_d;
      m_data_q  <= m_data_d;
      m_user_q  <= m_user_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
      upd_q     <= upd_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
      rdy_en_q  <= 1'b1;
`ifdef RESP_ID_WORD_EN
      hdr_last_q <= hdr_last_d;
`endif
    end
  end

  always_comb begin
    reg_map_out = '0;
    for (int k = 0; k < NUM_REG; k++) reg_map_out[32*k +: 32] = regs_q[k];
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tvalid = m_valid_q;
  assign reg_update    = upd_q;
  assign err_count     = err_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_axi_cmd_reg_map.sv
// Self-checking bench for axi_cmd_reg_map: directed frames then random frames,
// compared against a frame-level reference model of the register map.
module tb_axi_cmd_reg_map;

  localparam int          NUM_REG  = 6;
  localparam logic [31:0] HDR_WORD = 32'h52524343;
  localparam logic [31:0] BAD_WORD = 32'hDEADBEEF;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [31:0]           s_tdata;
  logic                  s_tvalid, s_tlast;
  logic [3:0]            s_tdest;
  logic [31:0]           s_tuser;
  logic                  s_tready;
  logic [31:0]           m_tdata, m_tuser;
  logic                  m_tvalid, m_tlast;
  logic                  m_tready = 1'b1;
  logic [32*NUM_REG-1:0] reg_map;
  logic                  reg_update;
  logic [7:0]            err_count, drop_count;

  axi_cmd_reg_map #(.NUM_REG(NUM_REG)) dut (
    .axi_tclk(clk), .axi_tresetn(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
    .reg_map_out(reg_map), .reg_update(reg_update),
    .err_count(err_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // reference model state
  logic [31:0] m_reg [NUM_REG];
  int          m_err, m_drop, m_upd;
  logic [64:0] exp_q[$];
  logic [64:0] got_q[$];
  int          got_upd;
  int          rdy_mode;
  logic [31:0] frm[$];

  logic [64:0] held;
  logic        held_v = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_REG; k++) m_reg[k] = 32'h0;
    m_err = 0; m_drop = 0; m_upd = 0; got_upd = 0;
    exp_q.delete(); got_q.delete();
  endtask

  // whole-frame behaviour: write pairs, readback list, or drop
  task automatic model_frame(input logic [3:0] dest, input logic [31:0] user);
    int n;
    logic [31:0] d;
    n = frm.size();
    if (dest == 4'd0) begin
      for (int i = 1; i < n; i += 2) begin
        if (i + 1 >= n) m_err = sat(m_err + 1);
        else if (frm[i] < 32'(NUM_REG)) begin
          m_reg[int'(frm[i])] = frm[i+1];
          m_upd++;
        end else m_err = sat(m_err + 1);
      end
    end else if (dest == 4'd2) begin
`ifdef RESP_ID_WORD_EN
      exp_q.push_back({1'b0, user, HDR_WORD});
      exp_q.push_back({n == 1, user, user});
`else
      exp_q.push_back({n == 1, user, HDR_WORD});
`endif
      for (int i = 1; i < n; i++) begin
        if (frm[i] < 32'(NUM_REG)) d = m_reg[int'(frm[i])];
        else begin
          d = BAD_WORD;
          m_err = sat(m_err + 1);
        end
        exp_q.push_back({i == n - 1, user, d});
      end
    end else begin
      m_drop = sat(m_drop + 1);
    end
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
    #1;
    while (!s_tready && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("accept_timeout", 32'(n < 200), 32'd1);
    @(posedge clk);
  endtask

  task automatic verify_frame();
    int sz;
    check("beat_count", 32'(got_q.size()), 32'(exp_q.size()));
    sz = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < sz; i++) begin
      check($sformatf("beat%0d_data", i), got_q[i][31:0], exp_q[i][31:0]);
      check($sformatf("beat%0d_user", i), got_q[i][63:32], exp_q[i][63:32]);
      check($sformatf("beat%0d_last", i), 32'(got_q[i][64]), 32'(exp_q[i][64]));
    end
    for (int k = 0; k < NUM_REG; k++)
      check($sformatf("reg%0d", k), reg_map[32*k +: 32], m_reg[k]);
    check("err_count", 32'(err_count), 32'(m_err));
    check("drop_count", 32'(drop_count), 32'(m_drop));
    check("reg_update_pulses", 32'(got_upd), 32'(m_upd));
    exp_q.delete(); got_q.delete();
  endtask

  task automatic send_frame(input logic [3:0] dest, input logic [31:0] user);
    int n;
    model_frame(dest, user);
    s_tdest = dest; s_tuser = user;
    for (int i = 0; i < frm.size(); i++) drive_beat(frm[i], i == frm.size() - 1);
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    n = 0;
    while ((got_q.size() < exp_q.size() || m_tvalid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n < 500), 32'd1);
    @(negedge clk); @(negedge clk); #2;
    verify_frame();
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8) return 32'(r);
    return 32'h100 | 32'($urandom_range(0, 5));
  endfunction

  // output sink: drives m_tready, records beats, checks hold and backpressure
  always @(negedge clk) begin
    case (rdy_mode)
      1:       m_tready = ~m_tready;
      2:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b1;
    endcase
    #1;
    if (!rst_n) held_v = 1'b0;
    else begin
      if (held_v) begin
        check("hold_valid", 32'(m_tvalid), 32'd1);
        check("hold_data", m_tdata, held[31:0]);
        check("hold_user", m_tuser, held[63:32]);
        check("hold_last", 32'(m_tlast), 32'(held[64]));
      end
      if (m_tvalid && !m_tready) check("s_ready_while_held", 32'(s_tready), 32'd0);
      if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tuser, m_tdata});
      held_v = m_tvalid && !m_tready;
      held   = {m_tlast, m_tuser, m_tdata};
      if (reg_update) got_upd++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rdy_mode = 0;
    rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 32'h0;
    s_tdest = 4'd0; s_tuser = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_m_tlast", 32'(m_tlast), 32'd0);
    check("rst_m_tdata", m_tdata, 32'd0);
    check("rst_m_tuser", m_tuser, 32'd0);
    check("rst_reg_update", 32'(reg_update), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_reg_any", 32'(reg_map != '0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic write of reg0 and reg3
    frm = '{32'hC0DE0001, 32'd0, 32'h1234, 32'd3, 32'hABCD};
    send_frame(4'd0, 32'h11);
    check("t1_reg0", reg_map[31:0], 32'h1234);
    check("t1_reg3", reg_map[127:96], 32'hABCD);

    // readback of the same registers
    frm = '{32'hC0DE0002, 32'd0, 32'd3};
    send_frame(4'd2, 32'd7);

    // readback under toggling output ready
    rdy_mode = 1;
    frm = '{32'hC0DE0003, 32'd3, 32'd0, 32'd3, 32'd1, 32'd0};
    send_frame(4'd2, 32'd9);
    rdy_mode = 0;

    // out-of-range write and read
    frm = '{32'hC0DE0004, 32'd9, 32'h5A5A};
    send_frame(4'd0, 32'h12);
    frm = '{32'hC0DE0005, 32'd9};
    send_frame(4'd2, 32'h13);
    check("t4_err_two", 32'(err_count), 32'd2);

    // drained frame, then a write frame truncated after its address
    frm = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
    send_frame(4'd1, 32'h14);
    check("t5_drop_one", 32'(drop_count), 32'd1);
    frm = '{32'hC0DE0006, 32'd2};
    send_frame(4'd0, 32'h15);
    check("t5_err_three", 32'(err_count), 32'd3);

    // reset while the write frame waits in WR_DATA
    s_tdest = 4'd0; s_tuser = 32'h16;
    drive_beat(32'hC0DE0007, 1'b0);
    drive_beat(32'd1, 1'b0);
    @(negedge clk);
    s_tdata = 32'h5555;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_regs_zero", 32'(reg_map != '0), 32'd0);
    check("mid_rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("mid_rst_reg_update", 32'(reg_update), 32'd0);
    check("mid_rst_s_tready", 32'(s_tready), 32'd0);
    check("mid_rst_err", 32'(err_count), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    frm = '{32'h5555, 32'd2, 32'h77};
    send_frame(4'd0, 32'h17);
    check("post_rst_reg2", reg_map[95:64], 32'h77);

    // random frames
    for (int f = 0; f < 40; f++) begin
      int kind, len;
      logic [3:0] dest;
      rdy_mode = $urandom_range(0, 2);
      kind = $urandom_range(0, 3);
      if (kind == 0) dest = 4'd0;
      else if (kind == 3) dest = 4'($urandom_range(3, 15));
      else dest = 4'd2;
      len = $urandom_range(1, 7);
      frm.delete();
      frm.push_back($urandom);
      for (int i = 1; i < len; i++) begin
        if (dest == 4'd2 || (dest == 4'd0 && (i % 2) == 1)) frm.push_back(rand_addr());
        else frm.push_back($urandom);
      end
      send_frame(dest, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
